emif_amm_arbiter: RTL and testbench

// Two-requester Avalon-MM arbiter in front of EMIF user port amm_0, in the emif_usr_clk domain.
// - Round-robin grant between requesters 0 and 1.
// - A write burst keeps the grant until its last beat is accepted.
// - Read data is returned to the requester that issued the read, using an in-order tag FIFO.
// - Lets the test sequencer and the ISSP/debug master share one DDR3 controller.

---
 rtl/emif_amm_arbiter_pkg.sv | 30 +++
 rtl/emif_tag_fifo.sv | 66 ++++++
 rtl/emif_amm_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_emif_amm_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emif_amm_arbiter_pkg.sv
// Shared definitions for the EMIF amm_0 two-requester arbiter.
//   - default widths for address, data, burstcount and tag FIFO depth
//   - FSM state encoding (IDLE=0, GRANT=1, WBURST=2)
//   - round-robin pick helper
package emif_amm_arbiter_pkg;

   localparam int AW_DEF        = 25;
   localparam int DW_DEF        = 320;
   localparam int BCW_DEF       = 7;
   localparam int TAG_DEPTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_WBURST = 2'd2
   } state_t;

   // With both requesters pending the one that did not win last time gets
   // the grant; with one pending that one gets it.
   function automatic logic rr_pick(input logic [1:0] pending, input logic last_grant);
      if (pending == 2'b11) begin
         return ~last_grant;
      end else if (pending[1]) begin
         return 1'b1;
      end else begin
         return 1'b0;
      end
   endfunction

endpackage

// File: rtl/emif_tag_fifo.sv
// In-order tag FIFO remembering {requester id, burstcount} for every read
// command forwarded to the EMIF, so returning beats can be steered back.
// Ports:
//   clk, rst            clock, synchronous active-high reset (empties FIFO)
//   push, push_data     write an entry (ignored when full)
//   pop                 drop the head entry (ignored when empty)
//   head                current head entry
//   full, empty         occupancy flags
// Push and pop in the same cycle both take effect; the count is unchanged.
module emif_tag_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/emif_amm_arbiter.sv
// Two-requester Avalon-MM arbiter in front of EMIF user port amm_0
// (emif_usr_clk domain). Lets the test sequencer and the debug master share
// one DDR3 controller.
// Ports:
//   emif_usr_clk, rst          clock, synchronous active-high reset
//   req_read/req_write[i]      requester i command strobes
//   req_address/writedata/byteenable/burstcount
//                              requester i packed at [i*W +: W]
//   req_ready[i]               requester i command accepted this cycle
//   req_readdata               shared read data, qualified by req_rddatavalid
//   req_rddatavalid            one-hot read data valid
//   amm_*                      EMIF command / response port
//   err                        sticky protocol error, cleared only by rst
//   dbg_state                  current FSM state (state_t encoding)
// Handshake: a command beat transfers on a rising edge where the master's
// read/write strobe and the slave's ready are both high; the master holds
// the command stable until then. Read data has no back-pressure.
module emif_amm_arbiter
   import emif_amm_arbiter_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int BCW       = BCW_DEF,
   parameter int TAG_DEPTH = TAG_DEPTH_DEF,
   localparam int BW       = DW / 8
) (
   input  logic              emif_usr_clk,
   input  logic              rst,
   input  logic [1:0]        req_read,
   input  logic [1:0]        req_write,
   input  logic [2*AW-1:0]   req_address,
   input  logic [2*DW-1:0]   req_writedata,
   input  logic [2*BW-1:0]   req_byteenable,
   input  logic [2*BCW-1:0]  req_burstcount,
   output logic [1:0]        req_ready,
   output logic [DW-1:0]     req_readdata,
   output logic [1:0]        req_rddatavalid,
   input  logic              amm_ready,
   output logic              amm_read,
   output logic              amm_write,
   output logic [AW-1:0]     amm_address,
   output logic [DW-1:0]     amm_writedata,
   output logic [BW-1:0]     amm_byteenable,
   output logic [BCW-1:0]    amm_burstcount,
   input  logic [DW-1:0]     amm_readdata,
   input  logic              amm_readdatavalid,
   output logic              err,
   output logic [1:0]        dbg_state
);

   state_t         state_q, state_d;
   logic           g_q, g_d;
   logic           last_grant_q, last_grant_d;
   logic [BCW-1:0] beats_left_q, beats_left_d;
   logic [BCW-1:0] rd_cnt_q;
   logic           err_q;
   logic           err_set;

   // Command of the granted requester
   logic           sel_read;
   logic           sel_write;
   logic [AW-1:0]  sel_address;
   logic [DW-1:0]  sel_writedata;
   logic [BW-1:0]  sel_byteenable;
   logic [BCW-1:0] sel_bc;
   logic [BCW-1:0] sel_bc_eff;
   logic [1:0]     g_onehot;
   logic [1:0]     pending;

   // Tag FIFO
   logic           fifo_push;
   logic           fifo_pop;
   logic [BCW:0]   fifo_head;
   logic           fifo_full;
   logic           fifo_empty;
   logic           head_id;
   logic [BCW-1:0] head_bc;
   logic           rd_hit;
   logic           rd_orphan;

   assign sel_read       = g_q ? req_read[1]  : req_read[0];
   assign sel_write      = g_q ? req_write[1] : req_write[0];
   assign sel_address    = g_q ? req_address[AW +: AW]     : req_address[0 +: AW];
   assign sel_writedata  = g_q ? req_writedata[DW +: DW]   : req_writedata[0 +: DW];
   assign sel_byteenable = g_q ? req_byteenable[BW +: BW]  : req_byteenable[0 +: BW];
   assign sel_bc         = g_q ? req_burstcount[BCW +: BCW] : req_burstcount[0 +: BCW];
   // Burstcount 0 is illegal on Avalon; it is carried as a single beat.
   assign sel_bc_eff     = (sel_bc == '0) ? BCW'(1) : sel_bc;
   assign g_onehot       = g_q ? 2'b10 : 2'b01;

   // Reads are held back while every tag slot is in use.
   assign pending = (req_read & {2{~fifo_full}}) | req_write;

   always_comb begin
      state_d        = state_q;
      g_d            = g_q;
      last_grant_d   = last_grant_q;
      beats_left_d   = beats_left_q;
      amm_read       = 1'b0;
      amm_write      = 1'b0;
      amm_address    = '0;
      amm_writedata  = '0;
      amm_byteenable = '0;
      amm_burstcount = '0;
      req_ready      = 2'b00;
      fifo_push      = 1'b0;
      err_set        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|pending) begin
               g_d     = rr_pick(pending, last_grant_q);
               state_d = ST_GRANT;
            end
         end

         ST_GRANT: begin
            amm_address    = sel_address;
            amm_writedata  = sel_writedata;
            amm_byteenable = sel_byteenable;
            amm_burstcount = sel_bc_eff;
            // Write wins when a requester raises both strobes.
            amm_write      = sel_write;
            amm_read       = sel_read & ~sel_write & ~fifo_full;
            req_ready      = g_onehot & {2{amm_ready & (amm_read | amm_write)}};
            if (sel_read && sel_write) begin
               err_set = 1'b1;
            end
            if (amm_ready && amm_write) begin
               if (sel_bc == '0) begin
                  err_set = 1'b1;
               end
               beats_left_d = sel_bc_eff - BCW'(1);
               last_grant_d = g_q;
               state_d      = (sel_bc_eff == BCW'(1)) ? ST_IDLE : ST_WBURST;
            end else if (amm_ready && amm_read) begin
               if (sel_bc == '0) begin
                  err_set = 1'b1;
               end
               fifo_push    = 1'b1;
               last_grant_d = g_q;
               state_d      = ST_IDLE;
            end
         end

         ST_WBURST: begin
            // Only write beats of the burst owner pass; a read here is an error
            // and is never forwarded.
            amm_address    = sel_address;
            amm_writedata  = sel_writedata;
            amm_byteenable = sel_byteenable;
            amm_burstcount = sel_bc_eff;
            amm_write      = sel_write;
            req_ready      = g_onehot & {2{amm_ready & sel_write}};
            if (sel_read) begin
               err_set = 1'b1;
            end
            if (amm_ready && sel_write) begin
               beats_left_d = beats_left_q - BCW'(1);
               if (beats_left_q == BCW'(1)) begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge emif_usr_clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         g_q          <= 1'b0;
         last_grant_q <= 1'b1;
         beats_left_q <= '0;
      end else begin
         state_q      <= state_d;
         g_q          <= g_d;
         last_grant_q <= last_grant_d;
         beats_left_q <= beats_left_d;
      end
   end

   emif_tag_fifo #(
      .W     (BCW + 1),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk       (emif_usr_clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data ({g_q, sel_bc_eff}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Read return: zero-latency steering by the head tag; the head retires on
   // its last beat.
   assign head_id         = fifo_head[BCW];
   assign head_bc         = fifo_head[BCW-1:0];
   assign rd_hit          = amm_readdatavalid & ~fifo_empty;
   assign rd_orphan       = amm_readdatavalid & fifo_empty;
   assign fifo_pop        = rd_hit & ((rd_cnt_q + BCW'(1)) == head_bc);
   assign req_readdata    = amm_readdata;
   assign req_rddatavalid = {rd_hit & head_id, rd_hit & ~head_id};

   always_ff @(posedge emif_usr_clk) begin
      if (rst) begin
         rd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (rd_hit) begin
            rd_cnt_q <= fifo_pop ? '0 : rd_cnt_q + BCW'(1);
         end
         err_q <= err_q | err_set | rd_orphan;
      end
   end

   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_emif_amm_arbiter.sv
// Directed bench for emif_amm_arbiter: command arbitration, write bursts,
// tag FIFO back-pressure, read return steering and error flagging.
module tb_emif_amm_arbiter;
   import emif_amm_arbiter_pkg::*;

   localparam int AW  = 25;
   localparam int DW  = 320;
   localparam int BCW = 7;
   localparam int BW  = DW / 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req_read;
   logic [1:0]        req_write;
   logic [2*AW-1:0]   req_address;
   logic [2*DW-1:0]   req_writedata;
   logic [2*BW-1:0]   req_byteenable;
   logic [2*BCW-1:0]  req_burstcount;
   logic [1:0]        req_ready;
   logic [DW-1:0]     req_readdata;
   logic [1:0]        req_rddatavalid;
   logic              amm_ready;
   logic              amm_read;
   logic              amm_write;
   logic [AW-1:0]     amm_address;
   logic [DW-1:0]     amm_writedata;
   logic [BW-1:0]     amm_byteenable;
   logic [BCW-1:0]    amm_burstcount;
   logic [DW-1:0]     amm_readdata;
   logic              amm_readdatavalid;
   logic              err;
   logic [1:0]        dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW:0]   exp_q[$];   // {requester id, data} in expected return order
   logic [DW-1:0] wr_log[$];  // write beats accepted by the EMIF
   logic [DW-1:0] wv[4];

   emif_amm_arbiter #(
      .AW (AW), .DW (DW), .BCW (BCW), .TAG_DEPTH (8)
   ) dut (
      .emif_usr_clk      (clk),
      .rst               (rst),
      .req_read          (req_read),
      .req_write         (req_write),
      .req_address       (req_address),
      .req_writedata     (req_writedata),
      .req_byteenable    (req_byteenable),
      .req_burstcount    (req_burstcount),
      .req_ready         (req_ready),
      .req_readdata      (req_readdata),
      .req_rddatavalid   (req_rddatavalid),
      .amm_ready         (amm_ready),
      .amm_read          (amm_read),
      .amm_write         (amm_write),
      .amm_address       (amm_address),
      .amm_writedata     (amm_writedata),
      .amm_byteenable    (amm_byteenable),
      .amm_burstcount    (amm_burstcount),
      .amm_readdata      (amm_readdata),
      .amm_readdatavalid (amm_readdatavalid),
      .err               (err),
      .dbg_state         (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      req_read          = 2'b00;
      req_write         = 2'b00;
      req_address       = '0;
      req_writedata     = '0;
      req_byteenable    = '0;
      req_burstcount    = '0;
      amm_ready         = 1'b1;
      amm_readdata      = '0;
      amm_readdatavalid = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_cmd(input int id, input logic rd, input logic wr,
                          input logic [AW-1:0] addr, input logic [BCW-1:0] bc,
                          input logic [DW-1:0] wd);
      req_read[id]                  = rd;
      req_write[id]                 = wr;
      req_address[id*AW +: AW]      = addr;
      req_burstcount[id*BCW +: BCW] = bc;
      req_writedata[id*DW +: DW]    = wd;
      req_byteenable[id*BW +: BW]   = '1;
   endtask

   task automatic clr_cmd(input int id);
      req_read[id]  = 1'b0;
      req_write[id] = 1'b0;
   endtask

   // One EMIF read-data beat; exp_valid=0 means the beat must be dropped.
   task automatic ret_beat(input logic [DW-1:0] d, input logic id, input logic exp_valid);
      if (exp_valid) exp_q.push_back({id, d});
      amm_readdata      = d;
      amm_readdatavalid = 1'b1;
      settle();
      check("ret_valid", req_rddatavalid, exp_valid ? (id ? 2'b10 : 2'b01) : 2'b00);
      tick();
      amm_readdatavalid = 1'b0;
   endtask

   // ---------------- scoreboard / monitors ----------------
   always @(negedge clk) begin
      if (req_rddatavalid != 2'b00) begin
         if (exp_q.size() == 0) begin
            check("rd_unexpected", req_rddatavalid, 2'b00);
         end else begin
            logic [DW:0] e;
            e = exp_q.pop_front();
            check("rd_id", req_rddatavalid, e[DW] ? 2'b10 : 2'b01);
            check("rd_data", req_readdata, e[DW-1:0]);
         end
      end
      if (amm_write && amm_ready) wr_log.push_back(amm_writedata);
   end

   task automatic check_wr_log(input string tag);
      check({tag, "_nbeats"}, wr_log.size(), 4);
      for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
         check({tag, "_beat"}, wr_log[i], wv[i]);
      end
   endtask

   // ---------------- directed tests ----------------
   initial begin
      for (int i = 0; i < 4; i++) wv[i] = {10{32'hC0DE_0000 + 32'(i)}};

      do_reset();
      settle();
      check("rst_amm_read", amm_read, 0);
      check("rst_amm_write", amm_write, 0);
      check("rst_amm_address", amm_address, 0);
      check("rst_amm_writedata", amm_writedata, 0);
      check("rst_amm_byteenable", amm_byteenable, 0);
      check("rst_amm_burstcount", amm_burstcount, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rddatavalid", req_rddatavalid, 0);
      check("rst_err", err, 0);
      check("rst_state", dbg_state, ST_IDLE);

      // 1) single read from requester 0
      do_reset();
      set_cmd(0, 1, 0, 25'd1, 7'd1, '0);
      settle();
      check("t1_bubble", amm_read, 0);
      tick(); settle();
      check("t1_amm_read", amm_read, 1);
      check("t1_addr", amm_address, 1);
      check("t1_ready", req_ready, 2'b01);
      check("t1_state", dbg_state, ST_GRANT);
      tick(); clr_cmd(0); settle();
      check("t1_read_done", amm_read, 0);
      check("t1_idle", dbg_state, ST_IDLE);
      ret_beat({10{32'hD1D1_0001}}, 1'b0, 1'b1);
      check("t1_err", err, 0);

      // 2) write burst 4 from req0 against a concurrent read from req1
      do_reset();
      wr_log.delete();
      set_cmd(0, 0, 1, 25'h10, 7'd4, wv[0]);
      set_cmd(1, 1, 0, 25'h20, 7'd1, '0);
      settle();
      check("t2_bubble", amm_write, 0);
      tick(); settle();
      check("t2_ready0", req_ready, 2'b01);
      check("t2_amm_write", amm_write, 1);
      check("t2_bc", amm_burstcount, 4);
      check("t2_addr", amm_address, 25'h10);
      for (int b = 1; b < 4; b++) begin
         tick();
         req_writedata[0 +: DW] = wv[b];
         settle();
         check("t2_wburst_state", dbg_state, ST_WBURST);
         check("t2_wburst_ready", req_ready, 2'b01);
         check("t2_no_read", amm_read, 0);
      end
      tick(); clr_cmd(0); settle();
      check("t2_burst_end", dbg_state, ST_IDLE);
      tick(); settle();
      check("t2_ready1", req_ready, 2'b10);
      check("t2_read1", amm_read, 1);
      check("t2_addr1", amm_address, 25'h20);
      tick(); clr_cmd(1);
      ret_beat({10{32'hD2D2_0002}}, 1'b1, 1'b1);
      check_wr_log("t2_wr");
      check("t2_err", err, 0);

      // 3) both requesters reading continuously alternate grants
      do_reset();
      set_cmd(0, 1, 0, 25'h100, 7'd1, '0);
      set_cmd(1, 1, 0, 25'h200, 7'd1, '0);
      for (int k = 0; k < 4; k++) begin
         tick(); settle();
         check("t3_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         check("t3_addr", amm_address, (k % 2 == 0) ? 25'h100 : 25'h200);
         tick();
      end
      clr_cmd(0); clr_cmd(1);
      for (int k = 0; k < 4; k++) begin
         ret_beat({10{32'hD3D3_0000 + 32'(k)}}, 1'(k % 2), 1'b1);
      end

      // 4) tag FIFO full blocks the 9th read until one returns
      do_reset();
      set_cmd(0, 1, 0, 25'h300, 7'd1, '0);
      for (int k = 0; k < 8; k++) begin
         tick(); settle();
         check("t4_fill_ready", req_ready, 2'b01);
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         tick(); settle();
         check("t4_blocked_ready", req_ready, 2'b00);
         check("t4_blocked_read", amm_read, 0);
         check("t4_blocked_state", dbg_state, ST_IDLE);
      end
      ret_beat({10{32'hD4D4_0000}}, 1'b0, 1'b1);
      settle();
      check("t4_still_idle", dbg_state, ST_IDLE);
      tick(); settle();
      check("t4_ninth_ready", req_ready, 2'b01);
      check("t4_ninth_read", amm_read, 1);
      tick(); clr_cmd(0);
      for (int k = 1; k < 9; k++) begin
         ret_beat({10{32'hD4D4_0000 + 32'(k)}}, 1'b0, 1'b1);
      end

      // 5) EMIF stall in the middle of a write burst
      do_reset();
      wr_log.delete();
      set_cmd(0, 0, 1, 25'h400, 7'd4, wv[0]);
      tick();
      tick();
      req_writedata[0 +: DW] = wv[1];
      tick();
      req_writedata[0 +: DW] = wv[2];
      amm_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         settle();
         check("t5_hold_write", amm_write, 1);
         check("t5_hold_data", amm_writedata, wv[2]);
         check("t5_hold_addr", amm_address, 25'h400);
         check("t5_hold_ready", req_ready, 2'b00);
         check("t5_hold_state", dbg_state, ST_WBURST);
         tick();
      end
      amm_ready = 1'b1;
      settle();
      check("t5_resume_ready", req_ready, 2'b01);
      tick();
      req_writedata[0 +: DW] = wv[3];
      settle();
      check("t5_last_beat_state", dbg_state, ST_WBURST);
      tick(); clr_cmd(0); settle();
      check("t5_done_state", dbg_state, ST_IDLE);
      check_wr_log("t5_wr");
      check("t5_err", err, 0);

      // 6) reset with three reads outstanding; late returns are orphans
      do_reset();
      set_cmd(0, 1, 0, 25'h500, 7'd1, '0);
      for (int k = 0; k < 3; k++) begin
         tick();
         tick();
      end
      clr_cmd(0);
      settle();
      check("t6_err_before", err, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check("t6_state_after_rst", dbg_state, ST_IDLE);
      ret_beat({10{32'hD6D6_0000}}, 1'b0, 1'b0);
      ret_beat({10{32'hD6D6_0001}}, 1'b0, 1'b0);
      settle();
      check("t6_err", err, 1);
      check("t6_state", dbg_state, ST_IDLE);

      // 7) burstcount 0 counts as one beat; burst-2 read from req1 follows
      do_reset();
      set_cmd(0, 1, 0, 25'h600, 7'd0, '0);
      tick(); settle();
      check("t7_bc0_sent_as_1", amm_burstcount, 1);
      tick(); clr_cmd(0);
      set_cmd(1, 1, 0, 25'h610, 7'd2, '0);
      tick(); settle();
      check("t7_ready1", req_ready, 2'b10);
      check("t7_bc2", amm_burstcount, 2);
      tick(); clr_cmd(1); settle();
      check("t7_err", err, 1);
      ret_beat({10{32'hD7D7_0000}}, 1'b0, 1'b1);
      ret_beat({10{32'hD7D7_0001}}, 1'b1, 1'b1);
      ret_beat({10{32'hD7D7_0002}}, 1'b1, 1'b1);

      // 8) read and write together: write wins, error flagged, no tag pushed
      do_reset();
      set_cmd(0, 1, 1, 25'h700, 7'd1, wv[0]);
      tick(); settle();
      check("t8_write_wins", amm_write, 1);
      check("t8_no_read", amm_read, 0);
      tick(); clr_cmd(0); settle();
      check("t8_err", err, 1);
      check("t8_state", dbg_state, ST_IDLE);
      ret_beat({10{32'hD8D8_0000}}, 1'b0, 1'b0);

      tick();
      check("exp_q_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
